// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM-stage control and the data-memory responder.
interface data_mem_responder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              Enable_signal;
  logic              RW_enable;
  logic              Size_enable;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output Enable_signal, RW_enable, Size_enable, address, data_in,
    input  data_out, busy, done, err
  );

  modport slave (
    input  Enable_signal, RW_enable, Size_enable, address, data_in,
    output data_out, busy, done, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency, big-endian, byte-addressed data memory for the MEM stage.
module data_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 R,
  data_mem_responder_if.slave  bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_rw, w_rw_nxt;
  logic              r_size, w_size_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic [31:0]       r_data_out, w_data_out_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              w_mem_we;
  logic              w_misaligned;
  logic [ADDR_W-1:0] w_a1, w_a2, w_a3;
  logic [31:0]       w_rd_word;

  logic [7:0] r_mem [DEPTH];

  assign w_misaligned = ~bus.Size_enable && (bus.address[1:0] != 2'b00);
  assign w_a1 = r_addr + ADDR_W'(1);
  assign w_a2 = r_addr + ADDR_W'(2);
  assign w_a3 = r_addr + ADDR_W'(3);
  // Lowest address carries the most significant byte.
  assign w_rd_word = {r_mem[r_addr], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};

  assign bus.data_out = r_data_out;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

  // State and output registers; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_size     <= 1'b0;
      r_wdata    <= '0;
      r_data_out <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr     <= w_addr_nxt;
      r_rw       <= w_rw_nxt;
      r_size     <= w_size_nxt;
      r_wdata    <= w_wdata_nxt;
      r_data_out <= w_data_out_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Next-state logic: capture in IDLE, count down in WAIT, complete at zero.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_addr_nxt     = r_addr;
    w_rw_nxt       = r_rw;
    w_size_nxt     = r_size;
    w_wdata_nxt    = r_wdata;
    w_data_out_nxt = r_data_out;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_mem_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Enable_signal) begin
          w_addr_nxt  = bus.address;
          w_rw_nxt    = bus.RW_enable;
          w_size_nxt  = bus.Size_enable;
          w_wdata_nxt = bus.data_in;
          if (w_misaligned) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_W'(LATENCY);
            w_busy_nxt  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          if (r_rw) begin
            w_mem_we = 1'b1;
          end else if (r_size) begin
            w_data_out_nxt = {24'h0, r_mem[r_addr]};
          end else begin
            w_data_out_nxt = w_rd_word;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      if (r_size) begin
        r_mem[r_addr] <= r_wdata[7:0];
      end else begin
        r_mem[r_addr] <= r_wdata[31:24];
        r_mem[w_a1]   <= r_wdata[23:16];
        r_mem[w_a2]   <= r_wdata[15:8];
        r_mem[w_a3]   <= r_wdata[7:0];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: reference byte array model plus done-driven monitor.
module tb_data_mem_responder;
  localparam int unsigned AW  = 8;
  localparam int unsigned LAT = 2;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic R   = 1'b0;

  data_mem_responder_if #(.ADDR_W(AW)) bus ();
  data_mem_responder_if #(.ADDR_W(AW)) bus0 ();

  data_mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (.clk(clk), .R(R), .bus(bus));
  data_mem_responder #(.ADDR_W(AW), .LATENCY(0))   u_dut0 (.clk(clk), .R(R), .bus(bus0));

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  int   n_done   = 0;
  exp_t q[$];

  logic [7:0]  ref_mem [256];
  logic [31:0] last_load = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = ref_mem[a];
    b1 = ref_mem[8'(a + 8'd1)];
    b2 = ref_mem[8'(a + 8'd2)];
    b3 = ref_mem[8'(a + 8'd3)];
    return {b0, b1, b2, b3};
  endfunction

  // Reference: applies a request to the byte array and queues the expected completion.
  task automatic model_push(input logic rw, input logic sz, input logic [7:0] a,
                            input logic [31:0] d, output logic is_err);
    exp_t e;
    is_err = (!sz && (a[1:0] != 2'b00));
    if (!is_err) begin
      if (rw) begin
        if (sz) ref_mem[a] = d[7:0];
        else begin
          ref_mem[a]             = d[31:24];
          ref_mem[8'(a + 8'd1)]  = d[23:16];
          ref_mem[8'(a + 8'd2)]  = d[15:8];
          ref_mem[8'(a + 8'd3)]  = d[7:0];
        end
      end else begin
        last_load = sz ? {24'h0, ref_mem[a]} : ref_word(a);
      end
    end
    e.err  = is_err;
    e.data = last_load;
    q.push_back(e);
  endtask

  // Monitor: every done pulse retires the oldest expected response.
  always @(negedge clk) begin
    if (R) begin
      chk("err_without_done", 32'(bus.err & ~bus.done), 32'(0));
      if (bus.done) begin
        exp_t e;
        n_done++;
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_done: done=1 with no request outstanding at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("resp_err", 32'(bus.err), 32'(e.err));
          chk("resp_data_out", bus.data_out, e.data);
        end
      end
    end
  end

  // Issues one request on the LATENCY=2 instance when it is idle and checks busy length.
  task automatic do_req(input logic rw, input logic sz, input logic [7:0] a, input logic [31:0] d);
    int   t;
    int   cnt;
    logic is_err;
    t = 0;
    while (bus.busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("idle_timeout", 32'(1), 32'(0));
    model_push(rw, sz, a, d, is_err);
    bus.Enable_signal = 1'b1;
    bus.RW_enable     = rw;
    bus.Size_enable   = sz;
    bus.address       = a;
    bus.data_in       = d;
    @(negedge clk);
    bus.Enable_signal = 1'b0;
    bus.address       = 8'($urandom);
    bus.data_in       = $urandom;
    bus.RW_enable     = 1'($urandom);
    bus.Size_enable   = 1'($urandom);
    if (is_err) begin
      chk("err_busy_low", 32'(bus.busy), 32'(0));
    end else begin
      cnt = 0;
      while (bus.busy && cnt < 40) begin
        cnt++;
        @(negedge clk);
      end
      chk("busy_cycles", 32'(cnt), 32'(LAT + 1));
    end
  endtask

  // Zero-latency instance: done must appear one edge after capture.
  task automatic do_req0(input logic rw, input logic sz, input logic [7:0] a, input logic [31:0] d);
    bus0.Enable_signal = 1'b1;
    bus0.RW_enable     = rw;
    bus0.Size_enable   = sz;
    bus0.address       = a;
    bus0.data_in       = d;
    @(negedge clk);
    bus0.Enable_signal = 1'b0;
    bus0.data_in       = $urandom;
    chk("lat0_busy_after_capture", 32'(bus0.busy), 32'(1));
    chk("lat0_no_early_done", 32'(bus0.done), 32'(0));
    @(negedge clk);
    chk("lat0_done", 32'(bus0.done), 32'(1));
    chk("lat0_busy_clear", 32'(bus0.busy), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  a;
    logic        rw, sz, dummy;
    int          done_before, t;
    logic [31:0] old40;

    bus.Enable_signal  = 1'b0; bus.RW_enable  = 1'b0; bus.Size_enable  = 1'b0;
    bus.address        = '0;   bus.data_in    = '0;
    bus0.Enable_signal = 1'b0; bus0.RW_enable = 1'b0; bus0.Size_enable = 1'b0;
    bus0.address       = '0;   bus0.data_in   = '0;

    // Reset state and idle with no requests.
    #3;
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_err", 32'(bus.err), 32'(0));
    @(negedge clk);
    R = 1'b1;
    done_before = n_done;
    repeat (10) @(negedge clk);
    chk("idle_no_done", 32'(n_done - done_before), 32'(0));

    // Fill the array so every load has a known expectation.
    for (int i = 0; i < 64; i++) do_req(1'b1, 1'b0, 8'(i * 4), $urandom);

    // Word store/load and big-endian byte loads.
    do_req(1'b1, 1'b0, 8'h10, 32'hDEADBEEF);
    do_req(1'b0, 1'b0, 8'h10, 32'h0);
    chk("load_word_10", bus.data_out, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 8'h10, 32'h0);
    chk("load_byte_10", bus.data_out, 32'h000000DE);
    do_req(1'b0, 1'b1, 8'h13, 32'h0);
    chk("load_byte_13", bus.data_out, 32'h000000EF);

    // Byte store merges into an existing word.
    do_req(1'b1, 1'b1, 8'h11, 32'h123456A5);
    do_req(1'b0, 1'b0, 8'h10, 32'h0);
    chk("byte_merge", bus.data_out, 32'hDEA5BEEF);

    // Misaligned word load is rejected without side effects.
    do_req(1'b0, 1'b0, 8'h22, 32'h0);
    chk("misalign_data_out_kept", bus.data_out, 32'hDEA5BEEF);
    do_req(1'b0, 1'b0, 8'h20, 32'h0);

    // Continuous enable: acceptance only in IDLE, one per LAT+2 cycles.
    for (int i = 0; i < 16; i++) begin
      if (i >= 1) chk("b2b_busy", 32'(bus.busy), 32'(((i - 1) % (LAT + 2)) != (LAT + 1)));
      a = (((i / 3) % 2) == 0) ? 8'h10 : 8'h20;
      bus.Enable_signal = 1'b1;
      bus.RW_enable     = 1'b0;
      bus.Size_enable   = 1'b0;
      bus.address       = a;
      if ((i % (LAT + 2)) == 0) model_push(1'b0, 1'b0, a, 32'h0, dummy);
      @(negedge clk);
    end
    bus.Enable_signal = 1'b0;
    t = 0;
    while (bus.busy && t < 50) begin
      @(negedge clk);
      t++;
    end

    // Top byte address.
    d = $urandom;
    do_req(1'b1, 1'b1, 8'hFF, d);
    do_req(1'b0, 1'b1, 8'hFF, 32'h0);
    chk("top_byte", bus.data_out, {24'h0, d[7:0]});
    do_req(1'b1, 1'b0, 8'hFC, 32'hA1B2C3D4);
    do_req(1'b0, 1'b0, 8'hFC, 32'h0);
    chk("top_word", bus.data_out, 32'hA1B2C3D4);

    // Randomized traffic.
    for (int i = 0; i < 120; i++) begin
      rw = 1'($urandom);
      sz = 1'($urandom);
      a  = 8'($urandom);
      if (!sz && ($urandom_range(0, 5) != 0)) a[1:0] = 2'b00;
      do_req(rw, sz, a, $urandom);
    end

    // Abort a store with reset in WAIT.
    repeat (2) @(negedge clk);
    old40 = ref_word(8'h40);
    bus.Enable_signal = 1'b1;
    bus.RW_enable     = 1'b1;
    bus.Size_enable   = 1'b0;
    bus.address       = 8'h40;
    bus.data_in       = 32'hCAFEF00D;
    @(negedge clk);
    bus.Enable_signal = 1'b0;
    chk("abort_busy_in_wait", 32'(bus.busy), 32'(1));
    #2 R = 1'b0;
    #1;
    chk("abort_rst_data_out", bus.data_out, 32'h0);
    chk("abort_rst_busy", 32'(bus.busy), 32'(0));
    chk("abort_rst_done", 32'(bus.done), 32'(0));
    last_load = '0;
    @(negedge clk);
    R = 1'b1;
    done_before = n_done;
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(n_done - done_before), 32'(0));
    do_req(1'b0, 1'b0, 8'h40, 32'h0);
    chk("abort_ram_kept", bus.data_out, old40);

    // Zero-latency instance.
    do_req0(1'b1, 1'b0, 8'h10, 32'hDEADBEEF);
    chk("lat0_store_data_out", bus0.data_out, 32'h0);
    do_req0(1'b0, 1'b0, 8'h10, 32'h0);
    chk("lat0_load_word", bus0.data_out, 32'hDEADBEEF);
    do_req0(1'b0, 1'b1, 8'h13, 32'h0);
    chk("lat0_load_byte", bus0.data_out, 32'h000000EF);

    repeat (6) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
